// File: rtl/wb_stage_pkg.sv
// Shared register-file widths and write-back queue sizing.
package wb_stage_pkg;

    localparam int RegAddrBus = 5;
    localparam int RegDataBus = 32;
    localparam int WbQDepth   = 2;

    localparam logic [RegDataBus-1:0] ZeroWord  = '0;
    localparam logic [RegAddrBus-1:0] RegAddr_0 = '0;

endpackage

// File: rtl/wb_pend_queue.sv
// Pending late-write FIFO: per-entry valid bit, kill-by-address,
// and two address lookups so decode can see outstanding writes.
module wb_pend_queue
    import wb_stage_pkg::*;
#(
    parameter int DW    = RegDataBus,
    parameter int AW    = RegAddrBus,
    parameter int DEPTH = WbQDepth
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [AW-1:0] push_addr_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    input  logic          kill_i,
    input  logic [AW-1:0] kill_addr_i,
    input  logic [AW-1:0] look1_i,
    input  logic [AW-1:0] look2_i,
    output logic          hit1_o,
    output logic          hit2_o,
    output logic          head_valid_o,
    output logic          head_occ_o,
    output logic [AW-1:0] head_addr_o,
    output logic [DW-1:0] head_data_o,
    output logic          ready_o,
    output logic          full_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [AW-1:0]    addr_q [DEPTH];
    logic [AW-1:0]    addr_d [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DW-1:0]    data_d [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             keep;
    logic [DEPTH-1:0] m1, m2;

    // A push to $0, or to the address the stage is writing now, is
    // already superseded: complete the handshake but take no slot.
    assign keep = push_i && (push_addr_i != '0)
               && !(kill_i && (push_addr_i == kill_addr_i));

    always_comb begin
        vld_d  = vld_q;
        addr_d = addr_q;
        data_d = data_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_i && (addr_q[i] == kill_addr_i)) begin
                vld_d[i] = 1'b0;
            end
        end
        if (pop_i) begin
            vld_d[rptr_q] = 1'b0;
            rptr_d        = rptr_q + 1'b1;
        end
        if (keep) begin
            vld_d[wptr_q]  = 1'b1;
            addr_d[wptr_q] = push_addr_i;
            data_d[wptr_q] = push_data_i;
            wptr_d         = wptr_q + 1'b1;
        end
        cnt_d = cnt_q + {{PW{1'b0}}, keep} - {{PW{1'b0}}, pop_i};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
            data_q <= data_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        m1 = '0;
        m2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            m1[i] = vld_q[i] && (addr_q[i] == look1_i);
            m2[i] = vld_q[i] && (addr_q[i] == look2_i);
        end
    end

    assign hit1_o       = rst && (look1_i != '0) && (|m1);
    assign hit2_o       = rst && (look2_i != '0) && (|m2);
    assign head_valid_o = vld_q[rptr_q];
    assign head_occ_o   = (cnt_q != '0);
    assign head_addr_o  = addr_q[rptr_q];
    assign head_data_o  = data_q[rptr_q];
    assign ready_o      = rst && (cnt_q < FULL);
    assign full_o       = rst && (cnt_q == FULL);

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register plus merge of late multicycle
// results onto the single register-file write port.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_W = RegDataBus,
    parameter int ADDR_W = RegAddrBus,
    parameter int QDEPTH = WbQDepth
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_wreg,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              stall,
    input  logic              flush,
    input  logic              lr_valid,
    output logic              lr_ready,
    input  logic [ADDR_W-1:0] lr_addr,
    input  logic [DATA_W-1:0] lr_data,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_1,
    input  logic [ADDR_W-1:0] raddr_2,
    output logic              pend_hit1,
    output logic              pend_hit2,
    output logic              q_full
);

    logic              wreg_q, wreg_d;
    logic [ADDR_W-1:0] wd_q, wd_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              kill, pop, push, rdy;
    logic              hv, occ;
    logic [ADDR_W-1:0] ha;
    logic [DATA_W-1:0] hd;

    always_comb begin
        wreg_d  = mem_wreg;
        wd_d    = mem_wd;
        wdata_d = mem_wdata;
        if (flush || stall) begin
            wreg_d  = 1'b0;
            wd_d    = '0;
            wdata_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wreg_q  <= 1'b0;
            wd_q    <= '0;
            wdata_q <= '0;
        end else begin
            wreg_q  <= wreg_d;
            wd_q    <= wd_d;
            wdata_q <= wdata_d;
        end
    end

    // Queued results are older than the stage write, so a stage write
    // to the same register makes them dead.
    assign kill     = wreg_q && (wd_q != '0);
    assign pop      = occ && (!hv || !wreg_q);
    assign push     = lr_valid && rdy;
    assign lr_ready = rdy;

    wb_pend_queue #(
        .DW    (DATA_W),
        .AW    (ADDR_W),
        .DEPTH (QDEPTH)
    ) u_q (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_addr_i  (lr_addr),
        .push_data_i  (lr_data),
        .pop_i        (pop),
        .kill_i       (kill),
        .kill_addr_i  (wd_q),
        .look1_i      (raddr_1),
        .look2_i      (raddr_2),
        .hit1_o       (pend_hit1),
        .hit2_o       (pend_hit2),
        .head_valid_o (hv),
        .head_occ_o   (occ),
        .head_addr_o  (ha),
        .head_data_o  (hd),
        .ready_o      (rdy),
        .full_o       (q_full)
    );

    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        if (rst) begin
            if (wreg_q) begin
                we    = 1'b1;
                waddr = wd_q;
                wdata = wdata_q;
            end else if (hv) begin
                we    = 1'b1;
                waddr = ha;
                wdata = hd;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: stage-register vector table plus hand sequences;
// every register-file write is matched against an expected-write queue.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_wreg;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata;
    logic        stall, flush;
    logic        lr_valid, lr_ready;
    logic [4:0]  lr_addr;
    logic [31:0] lr_data;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr_1, raddr_2;
    logic        pend_hit1, pend_hit2, q_full;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];

    typedef struct {
        logic        fl;
        logic        st;
        logic        wr;
        logic [4:0]  wd;
        logic [31:0] wdat;
        logic        ewe;
        logic [4:0]  ewa;
        logic [31:0] ewd;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    wb_stage dut (
        .clk       (clk),
        .rst       (rst),
        .mem_wreg  (mem_wreg),
        .mem_wd    (mem_wd),
        .mem_wdata (mem_wdata),
        .stall     (stall),
        .flush     (flush),
        .lr_valid  (lr_valid),
        .lr_ready  (lr_ready),
        .lr_addr   (lr_addr),
        .lr_data   (lr_data),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr_1   (raddr_1),
        .raddr_2   (raddr_2),
        .pend_hit1 (pend_hit1),
        .pend_hit2 (pend_hit2),
        .q_full    (q_full)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // Every write seen on the port must be the next expected one.
    always @(negedge clk) begin
        wr_t e;
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexp: got addr %0d data %h want no write",
                         waddr, wdata);
            end else begin
                e = exp_q.pop_front();
                chk("sb_addr", 32'(waddr), 32'(e.a));
                chk("sb_data", wdata, e.d);
            end
        end
    end

    initial begin
        tbl[0] = '{0, 0, 1, 5'd5,  32'h12345678, 1, 5'd5,  32'h12345678};
        tbl[1] = '{0, 0, 0, 5'd6,  32'h00000066, 0, 5'd0,  32'h0};
        tbl[2] = '{1, 0, 1, 5'd10, 32'h0000000A, 0, 5'd0,  32'h0};
        tbl[3] = '{0, 1, 1, 5'd11, 32'h0000000B, 0, 5'd0,  32'h0};
        tbl[4] = '{1, 1, 1, 5'd12, 32'h0000000C, 0, 5'd0,  32'h0};
        tbl[5] = '{0, 0, 1, 5'd0,  32'h00000055, 1, 5'd0,  32'h00000055};
        tbl[6] = '{0, 0, 1, 5'd31, 32'hFFFFFFFF, 1, 5'd31, 32'hFFFFFFFF};
        tbl[7] = '{0, 0, 0, 5'd3,  32'h00000077, 0, 5'd0,  32'h0};

        rst = 1'b0;
        mem_wreg = 1'b0; mem_wd = '0; mem_wdata = '0;
        stall = 1'b0; flush = 1'b0;
        lr_valid = 1'b0; lr_addr = '0; lr_data = '0;
        raddr_1 = '0; raddr_2 = '0;

        tick();
        tick();
        chk("rst_we", 32'(we), 0);
        chk("rst_waddr", 32'(waddr), 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_ready", 32'(lr_ready), 0);
        chk("rst_full", 32'(q_full), 0);
        rst = 1'b1;
        #1;
        chk("post_rst_ready", 32'(lr_ready), 1);

        for (int i = 0; i < 8; i++) begin
            flush     = tbl[i].fl;
            stall     = tbl[i].st;
            mem_wreg  = tbl[i].wr;
            mem_wd    = tbl[i].wd;
            mem_wdata = tbl[i].wdat;
            if (tbl[i].ewe) exp_wr(tbl[i].ewa, tbl[i].ewd);
            tick();
            chk($sformatf("v%0d_we", i), 32'(we), 32'(tbl[i].ewe));
            chk($sformatf("v%0d_waddr", i), 32'(waddr), 32'(tbl[i].ewa));
            chk($sformatf("v%0d_wdata", i), wdata, tbl[i].ewd);
            chk($sformatf("v%0d_ready", i), 32'(lr_ready), 1);
        end
        flush = 1'b0; stall = 1'b0; mem_wreg = 1'b0;
        tick();

        // single late result drains when the pipeline is idle
        raddr_1 = 5'd9;
        lr_valid = 1'b1; lr_addr = 5'd9; lr_data = 32'hAAAA0000;
        exp_wr(5'd9, 32'hAAAA0000);
        #1;
        chk("lr9_ready", 32'(lr_ready), 1);
        chk("lr9_pend_pre", 32'(pend_hit1), 0);
        tick();
        lr_valid = 1'b0;
        #1;
        chk("lr9_pend", 32'(pend_hit1), 1);
        chk("lr9_we", 32'(we), 1);
        chk("lr9_waddr", 32'(waddr), 9);
        tick();
        chk("lr9_pend_clr", 32'(pend_hit1), 0);
        chk("lr9_we_clr", 32'(we), 0);

        // queue fills while the stage writes every cycle
        raddr_1 = 5'd3; raddr_2 = 5'd4;
        mem_wreg = 1'b1; mem_wd = 5'd20; mem_wdata = 32'd100;
        lr_valid = 1'b1; lr_addr = 5'd3; lr_data = 32'h33;
        exp_wr(5'd20, 32'd100);
        tick();
        mem_wd = 5'd21; mem_wdata = 32'd101;
        lr_addr = 5'd4; lr_data = 32'h44;
        exp_wr(5'd21, 32'd101);
        #1;
        chk("c1_ready", 32'(lr_ready), 1);
        chk("c1_pend1", 32'(pend_hit1), 1);
        chk("c1_pend2", 32'(pend_hit2), 0);
        tick();
        mem_wd = 5'd22; mem_wdata = 32'd102;
        lr_addr = 5'd5; lr_data = 32'h55;
        exp_wr(5'd22, 32'd102);
        #1;
        chk("c2_full", 32'(q_full), 1);
        chk("c2_ready", 32'(lr_ready), 0);
        chk("c2_pend2", 32'(pend_hit2), 1);
        chk("c2_waddr", 32'(waddr), 21);
        tick();
        mem_wreg = 1'b0; lr_valid = 1'b0;
        exp_wr(5'd3, 32'h33);
        exp_wr(5'd4, 32'h44);
        #1;
        chk("c3_full", 32'(q_full), 1);
        chk("c3_ready", 32'(lr_ready), 0);
        chk("c3_waddr", 32'(waddr), 22);
        tick();
        chk("c4_we", 32'(we), 1);
        chk("c4_waddr", 32'(waddr), 3);
        tick();
        chk("c5_waddr", 32'(waddr), 4);
        chk("c5_ready", 32'(lr_ready), 1);
        chk("c5_pend1", 32'(pend_hit1), 0);
        tick();
        chk("c6_we", 32'(we), 0);
        chk("c6_pend2", 32'(pend_hit2), 0);
        chk("c6_full", 32'(q_full), 0);

        // queued r7 killed by a younger stage write to r7
        raddr_1 = 5'd7; raddr_2 = 5'd0;
        mem_wreg = 1'b1; mem_wd = 5'd11; mem_wdata = 32'hB;
        lr_valid = 1'b1; lr_addr = 5'd7; lr_data = 32'h1;
        exp_wr(5'd11, 32'hB);
        tick();
        lr_valid = 1'b0;
        mem_wd = 5'd7; mem_wdata = 32'h2;
        exp_wr(5'd7, 32'h2);
        #1;
        chk("k1_pend", 32'(pend_hit1), 1);
        chk("k1_waddr", 32'(waddr), 11);
        tick();
        mem_wreg = 1'b0;
        #1;
        chk("k2_pend", 32'(pend_hit1), 1);
        chk("k2_wdata", wdata, 32'h2);
        tick();
        chk("k3_pend", 32'(pend_hit1), 0);
        chk("k3_we", 32'(we), 0);
        tick();
        chk("k4_we", 32'(we), 0);
        chk("k4_ready", 32'(lr_ready), 1);

        // push on the same edge as a stage write to that address
        raddr_1 = 5'd12;
        mem_wreg = 1'b1; mem_wd = 5'd12; mem_wdata = 32'hC;
        exp_wr(5'd12, 32'hC);
        tick();
        mem_wreg = 1'b0;
        lr_valid = 1'b1; lr_addr = 5'd12; lr_data = 32'hD;
        #1;
        chk("s1_waddr", 32'(waddr), 12);
        tick();
        lr_valid = 1'b0;
        #1;
        chk("s2_pend", 32'(pend_hit1), 0);
        chk("s2_we", 32'(we), 0);
        tick();
        chk("s3_we", 32'(we), 0);

        // late result to r0 is accepted and dropped
        raddr_1 = 5'd0;
        lr_valid = 1'b1; lr_addr = 5'd0; lr_data = 32'hDEAD;
        #1;
        chk("z_ready", 32'(lr_ready), 1);
        tick();
        lr_valid = 1'b0;
        #1;
        chk("z_we", 32'(we), 0);
        chk("z_full", 32'(q_full), 0);
        tick();
        chk("z_we2", 32'(we), 0);

        // reset with two queued writes discards them
        raddr_1 = 5'd13; raddr_2 = 5'd14;
        mem_wreg = 1'b1; mem_wd = 5'd25; mem_wdata = 32'd250;
        lr_valid = 1'b1; lr_addr = 5'd13; lr_data = 32'd130;
        exp_wr(5'd25, 32'd250);
        tick();
        mem_wd = 5'd26; mem_wdata = 32'd260;
        lr_addr = 5'd14; lr_data = 32'd140;
        tick();
        mem_wreg = 1'b0; lr_valid = 1'b0;
        #1;
        chk("r_full", 32'(q_full), 1);
        chk("r_pend1", 32'(pend_hit1), 1);
        chk("r_pend2", 32'(pend_hit2), 1);
        rst = 1'b0;
        #1;
        chk("r_we", 32'(we), 0);
        chk("r_waddr", 32'(waddr), 0);
        chk("r_wdata", wdata, 0);
        chk("r_ready", 32'(lr_ready), 0);
        chk("r_fullz", 32'(q_full), 0);
        chk("r_pend1z", 32'(pend_hit1), 0);
        tick();
        chk("r2_we", 32'(we), 0);
        chk("r2_pend2", 32'(pend_hit2), 0);
        rst = 1'b1;
        tick();
        chk("r3_we", 32'(we), 0);
        chk("r3_ready", 32'(lr_ready), 1);
        chk("r3_full", 32'(q_full), 0);
        chk("r3_pend1", 32'(pend_hit1), 0);
        chk("r3_pend2", 32'(pend_hit2), 0);
        tick();
        chk("r4_we", 32'(we), 0);
        tick();

        chk("sb_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
